// File: rtl/mfcc_pkg.sv
// Shared types and constants for the MFCC front-end chain.
package mfcc_pkg;

    localparam int unsigned NFFT_DEF  = 512;
    localparam int unsigned RFFT_BINS = NFFT_DEF / 2 + 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        PAD      = 3'd2,
        START    = 3'd3,
        WAIT_FFT = 3'd4,
        FINISH   = 3'd5
    } seq_state_t;

    // Number of one-sided power bins (0..nfft/2) for a given FFT length.
    function automatic int unsigned rfft_bins(input int unsigned nfft);
        return nfft / 2 + 1;
    endfunction

endpackage

// File: rtl/fft_watchdog.sv
// Cycle counter that flags expiry once it has counted TIMEOUT_CYCLES-1 enabled cycles.
module fft_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 8192
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned     CNT_W      = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] PRE_EXPIRE = CNT_W'(TIMEOUT_CYCLES - 2);

    logic [CNT_W-1:0] cnt_q;
    logic             expired_q;

    // expired_q is registered alongside the count so it is high exactly while cnt_q == TIMEOUT_CYCLES-1.
    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else if (enable_i) begin
            cnt_q     <= cnt_q + CNT_W'(1);
            expired_q <= (cnt_q == PRE_EXPIRE);
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/fft_frame_sequencer.sv
// Loads one windowed frame into the FFT buffer, zero-pads, starts the FFT with a watchdog,
// and forwards the one-sided power spectrum to the mel stage.
module fft_frame_sequencer
    import mfcc_pkg::*;
#(
    parameter int unsigned NFFT           = NFFT_DEF,
    parameter int unsigned NFFT_LOG2      = $clog2(NFFT),
    parameter int unsigned FRAME_LEN      = 400,
    parameter int unsigned INPUT_WIDTH    = 16,
    parameter int unsigned COMPLEX_WIDTH  = 32,
    parameter int unsigned TIMEOUT_CYCLES = 8192,
    parameter int unsigned FRAME_CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable_i,
    input  logic                     sample_valid_i,
    input  logic [INPUT_WIDTH-1:0]   sample_i,
    output logic                     sample_ready_o,
    output logic                     fft_in_valid_o,
    output logic [NFFT_LOG2-1:0]     fft_frame_ptr_o,
    output logic [INPUT_WIDTH-1:0]   fft_real_o,
    output logic                     fft_start_o,
    input  logic                     fft_done_i,
    input  logic                     fft_power_valid_i,
    input  logic [NFFT_LOG2-1:0]     fft_power_ptr_i,
    input  logic [COMPLEX_WIDTH-1:0] fft_power_i,
    output logic                     bin_valid_o,
    output logic [NFFT_LOG2-1:0]     bin_idx_o,
    output logic [COMPLEX_WIDTH-1:0] bin_power_o,
    output logic                     frame_done_o,
    output logic [FRAME_CNT_W-1:0]   frame_cnt_o,
    output logic                     busy_o,
    output logic                     timeout_err_o
);

    // One extra bit so the pointer compare cannot wrap when FRAME_LEN == NFFT.
    localparam int unsigned          PTR_W       = NFFT_LOG2 + 1;
    localparam logic [PTR_W-1:0]     LAST_SAMPLE = PTR_W'(FRAME_LEN - 1);
    localparam logic [PTR_W-1:0]     LAST_PTR    = PTR_W'(NFFT - 1);
    localparam logic [NFFT_LOG2-1:0] LAST_BIN    = NFFT_LOG2'(rfft_bins(NFFT) - 1);

    seq_state_t               state_q;
    logic [PTR_W-1:0]         wp_q;
    logic                     in_valid_q;
    logic [NFFT_LOG2-1:0]     ptr_q;
    logic [INPUT_WIDTH-1:0]   real_q;
    logic                     start_q;
    logic                     frame_done_q;
    logic [FRAME_CNT_W-1:0]   frame_cnt_q;
    logic                     busy_q;
    logic                     timeout_err_q;
    logic                     bin_valid_q;
    logic [NFFT_LOG2-1:0]     bin_idx_q;
    logic [COMPLEX_WIDTH-1:0] bin_power_q;
    logic                     wd_clear;
    logic                     wd_enable;
    logic                     wd_expired;

    assign sample_ready_o = (state_q == LOAD);
    assign wd_clear       = (state_q == START);
    assign wd_enable      = (state_q == WAIT_FFT);

    fft_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (wd_clear),
        .enable_i  (wd_enable),
        .expired_o (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wp_q          <= '0;
            in_valid_q    <= 1'b0;
            ptr_q         <= '0;
            real_q        <= '0;
            start_q       <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_cnt_q   <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            bin_valid_q   <= 1'b0;
            bin_idx_q     <= '0;
            bin_power_q   <= '0;
        end else begin
            in_valid_q   <= 1'b0;
            start_q      <= 1'b0;
            frame_done_q <= 1'b0;

            // Power forwarding runs in every state; out-of-range bins are dropped.
            bin_valid_q <= fft_power_valid_i && (fft_power_ptr_i <= LAST_BIN);
            if (fft_power_valid_i && (fft_power_ptr_i <= LAST_BIN)) begin
                bin_idx_q   <= fft_power_ptr_i;
                bin_power_q <= fft_power_i;
            end

            unique case (state_q)
                IDLE: begin
                    if (enable_i) begin
                        wp_q    <= '0;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (sample_valid_i) begin
                        in_valid_q <= 1'b1;
                        ptr_q      <= wp_q[NFFT_LOG2-1:0];
                        real_q     <= sample_i;
                        wp_q       <= wp_q + PTR_W'(1);
                        if (wp_q == LAST_SAMPLE) begin
                            state_q <= (LAST_SAMPLE == LAST_PTR) ? START : PAD;
                        end
                    end
                end
                PAD: begin
                    in_valid_q <= 1'b1;
                    ptr_q      <= wp_q[NFFT_LOG2-1:0];
                    real_q     <= '0;
                    wp_q       <= wp_q + PTR_W'(1);
                    if (wp_q == LAST_PTR) begin
                        state_q <= START;
                    end
                end
                START: begin
                    start_q <= 1'b1;
                    state_q <= WAIT_FFT;
                end
                WAIT_FFT: begin
                    // Done takes priority over a timeout landing on the same cycle.
                    if (fft_done_i) begin
                        frame_done_q <= 1'b1;
                        frame_cnt_q  <= frame_cnt_q + FRAME_CNT_W'(1);
                        state_q      <= FINISH;
                    end else if (wd_expired) begin
                        timeout_err_q <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign fft_in_valid_o  = in_valid_q;
    assign fft_frame_ptr_o = ptr_q;
    assign fft_real_o      = real_q;
    assign fft_start_o     = start_q;
    assign frame_done_o    = frame_done_q;
    assign frame_cnt_o     = frame_cnt_q;
    assign busy_o          = busy_q;
    assign timeout_err_o   = timeout_err_q;
    assign bin_valid_o     = bin_valid_q;
    assign bin_idx_o       = bin_idx_q;
    assign bin_power_o     = bin_power_q;

endmodule
